// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - funct codes and multiply/divide FSM state shared by the ALU
package alu_pkg;

    // Decoder funct field values
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIVU  = 6'd27;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative unsigned multiply/divide engine owning HI/LO
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   start_mul/start_div one-cycle start strobes (only honoured while idle)
//   a, b                operands (multiplicand/multiplier, dividend/divisor)
//   busy                an operation is iterating
//   done                one-cycle pulse on the edge that updates hi/lo
//   hi, lo              result registers
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mul,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last;

    // Both algorithms share one working pair: work_hi is the running
    // partial product / remainder, work_lo the multiplier / quotient, and
    // op_q the multiplicand / divisor. The final {work_hi, work_lo} maps
    // directly onto {hi, lo} for either operation.
    logic [WIDTH-1:0] op_q;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    assign busy = (state != MD_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last      = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start_mul) begin
                    state_nxt = MD_MUL;
                end else if (start_div) begin
                    state_nxt = MD_DIV;
                end
            end
            MD_MUL, MD_DIV: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = MD_IDLE;
                end
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    // One iteration of either algorithm.
    always_comb begin
        // Shift-add: add multiplicand when the current multiplier LSB is set,
        // then shift the whole {carry, hi, lo} right by one.
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, op_q} : '0);
        // Restoring divide: bring the next dividend bit into the remainder
        // and subtract the divisor if it fits. The remainder stays below the
        // divisor, so a successful difference always fits in WIDTH bits.
        // A zero divisor always "fits", which yields all-ones quotient and
        // the dividend as remainder without special casing.
        rem_shift = {work_hi, work_lo[WIDTH-1]};
        div_ge    = (rem_shift >= {1'b0, op_q});
        div_diff  = rem_shift[WIDTH-1:0] - op_q;
        nxt_hi    = work_hi;
        nxt_lo    = work_lo;
        if (state == MD_MUL) begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end else if (state == MD_DIV) begin
            if (div_ge) begin
                nxt_hi = div_diff;
                nxt_lo = {work_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = rem_shift[WIDTH-1:0];
                nxt_lo = {work_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            op_q    <= '0;
            work_hi <= '0;
            work_lo <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= last;
            if (state == MD_IDLE) begin
                if (start_mul) begin
                    op_q    <= a;
                    work_lo <= b;
                    work_hi <= '0;
                    cnt     <= '0;
                end else if (start_div) begin
                    op_q    <= b;
                    work_lo <= a;
                    work_hi <= '0;
                    cnt     <= '0;
                end
            end else begin
                work_hi <= nxt_hi;
                work_lo <= nxt_lo;
                cnt     <= last ? '0 : cnt + CNT_W'(1);
                if (last) begin
                    hi <= nxt_hi;
                    lo <= nxt_lo;
                end
            end
        end
    end

endmodule

// File: rtl/muldiv_alu.sv
// rtl/muldiv_alu.sv - execute-stage ALU with single-cycle ops and iterative MULTU/DIVU
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   in_valid       Signal/dataA/dataB carry an op
//   in_ready       op can be accepted (no multiply/divide running)
//   Signal         funct code
//   dataA, dataB   operands
//   Output         registered result
//   out_valid      one-cycle pulse when Output is updated
//   busy           multiply/divide in progress
//   done           one-cycle pulse when HI/LO are updated
module muldiv_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] Output,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int SH_W = $clog2(WIDTH);

    logic             accept;
    logic             is_md;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] alu_res;

    assign in_ready = !busy;
    assign accept   = in_valid && in_ready;
    assign is_md    = (Signal == FN_MULTU) || (Signal == FN_DIVU);

    muldiv_seq #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_seq (
        .clk       (clk),
        .reset     (reset),
        .start_mul (accept && (Signal == FN_MULTU)),
        .start_div (accept && (Signal == FN_DIVU)),
        .a         (dataA),
        .b         (dataB),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always_comb begin
        alu_res = '0;
        case (Signal)
            FN_AND:  alu_res = dataA & dataB;
            FN_OR:   alu_res = dataA | dataB;
            FN_ADD:  alu_res = dataA + dataB;
            FN_SUB:  alu_res = dataA - dataB;
            FN_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
            FN_SRL:  alu_res = dataA >> dataB[SH_W-1:0];
            FN_MFHI: alu_res = hi;
            FN_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // MULTU/DIVU leave Output untouched; their results surface via MFHI/MFLO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Output    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= accept && !is_md;
            if (accept && !is_md) begin
                Output <= alu_res;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_alu.sv
// tb/tb_muldiv_alu.sv - self-checking bench for muldiv_alu at WIDTH 32 and 8
module tb_muldiv_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, busy, done;
    logic [5:0]  sig;
    logic [31:0] a, b, out;
    logic        v8, r8, ov8, bz8, dn8;
    logic [5:0]  s8;
    logic [7:0]  a8, b8, o8;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    muldiv_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Signal(sig), .dataA(a), .dataB(b), .Output(out),
        .out_valid(out_valid), .busy(busy), .done(done)
    );

    muldiv_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_ready(r8),
        .Signal(s8), .dataA(a8), .dataB(b8), .Output(o8),
        .out_valid(ov8), .busy(bz8), .done(dn8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y);
        case (fn)
            FN_AND:  return x & y;
            FN_OR:   return x | y;
            FN_ADD:  return x + y;
            FN_SUB:  return x - y;
            FN_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            FN_SRL:  return x >> y[4:0];
            FN_MFHI: return m_hi;
            FN_MFLO: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    task automatic op1(input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [31:0] exp;
        exp = ref_alu(fn, x, y);
        @(negedge clk);
        in_valid = 1'b1; sig = fn; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, " out_valid"}, 64'(out_valid), 64'd1);
        check({tag, " done"}, 64'(done), 64'd0);
        check(tag, 64'(out), 64'(exp));
    endtask

    task automatic md32(input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [31:0] prev;
        int k;
        @(negedge clk);
        prev = out;
        in_valid = 1'b1; sig = fn; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, " busy"}, 64'(busy), 64'd1);
        check({tag, " in_ready"}, 64'(in_ready), 64'd0);
        check({tag, " no out_valid"}, 64'(out_valid), 64'd0);
        k = 0;
        while (k < 100) begin
            @(posedge clk); #1;
            k++;
            if (done) break;
        end
        check({tag, " latency"}, 64'(k), 64'd32);
        check({tag, " busy end"}, 64'(busy), 64'd0);
        check({tag, " output held"}, 64'(out), 64'(prev));
        if (fn == FN_MULTU) begin
            {m_hi, m_lo} = 64'(x) * 64'(y);
        end else if (y == 32'd0) begin
            m_lo = '1; m_hi = x;
        end else begin
            m_lo = x / y; m_hi = x % y;
        end
        op1(FN_MFHI, 0, 0, {tag, " hi"});
        op1(FN_MFLO, 0, 0, {tag, " lo"});
    endtask

    task automatic op8(input logic [5:0] fn, output logic [7:0] r);
        @(negedge clk);
        v8 = 1'b1; s8 = fn;
        @(posedge clk); #1;
        v8 = 1'b0;
        check("w8 out_valid", 64'(ov8), 64'd1);
        r = o8;
    endtask

    task automatic md8(input logic [5:0] fn, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] eh, input logic [7:0] el, input string tag);
        int k;
        logic [7:0] r;
        @(negedge clk);
        v8 = 1'b1; s8 = fn; a8 = x; b8 = y;
        @(posedge clk); #1;
        v8 = 1'b0;
        k = 0;
        while (k < 100) begin
            @(posedge clk); #1;
            k++;
            if (dn8) break;
        end
        check({tag, " latency"}, 64'(k), 64'd8);
        op8(FN_MFHI, r);
        check({tag, " hi"}, 64'(r), 64'(eh));
        op8(FN_MFLO, r);
        check({tag, " lo"}, 64'(r), 64'(el));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [5:0]  fns [8];
        logic [5:0]  fn;
        logic [31:0] x, y;
        int k, dk, seen;

        fns = '{FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SRL, FN_MFHI, FN_MFLO};
        reset = 1'b0;
        in_valid = 1'b0; sig = '0; a = '0; b = '0;
        v8 = 1'b0; s8 = '0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst out", 64'(out), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        op1(FN_MFHI, 0, 0, "rst hi");

        // back-to-back single-cycle ops
        op1(FN_ADD, 32'd7, 32'd5, "add");
        op1(FN_SUB, 32'd3, 32'd5, "sub");
        op1(FN_SLT, 32'hFFFF_FFFF, 32'd1, "slt");
        op1(FN_SRL, 32'h8000_0000, 32'd31, "srl");
        op1(6'd63, 32'h1234, 32'h5678, "undef");

        md32(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul max");
        md32(FN_DIVU, 32'd100, 32'd7, "div 100/7");
        md32(FN_DIVU, 32'd9, 32'd0, "div by 0");

        // ADD held during MULTU must wait for done and be taken once
        @(negedge clk);
        in_valid = 1'b1; sig = FN_MULTU; a = 32'd6; b = 32'd7;
        @(posedge clk); #1;
        sig = FN_ADD; a = 32'd3; b = 32'd4;
        k = 0; dk = 0;
        while (k < 100) begin
            @(posedge clk); #1;
            k++;
            if (done) dk = k;
            if (out_valid) break;
        end
        in_valid = 1'b0;
        m_hi = 32'd0; m_lo = 32'd42;
        check("hold done cycle", 64'(dk), 64'd32);
        check("hold accept cycle", 64'(k), 64'd33);
        check("hold add result", 64'(out), 64'd7);
        @(posedge clk); #1;
        check("hold once", 64'(out_valid), 64'd0);
        op1(FN_MFLO, 0, 0, "hold lo");

        // random single-cycle ops
        repeat (150) begin
            if ($urandom_range(9) == 0) begin
                fn = 6'($urandom_range(63));
                if (fn == FN_MULTU || fn == FN_DIVU) fn = 6'd63;
            end else begin
                fn = fns[$urandom_range(7)];
            end
            x = $urandom;
            y = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom;
            op1(fn, x, y, "rand op");
        end

        // random multiply/divide
        repeat (6) begin
            x = $urandom;
            case ($urandom_range(2))
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 300));
                default: y = $urandom;
            endcase
            md32(($urandom_range(1) == 0) ? FN_MULTU : FN_DIVU, x, y, "rand md");
        end

        // 8-bit instance
        md8(FN_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01, "w8 mul");
        md8(FN_DIVU, 8'hFF, 8'h10, 8'h0F, 8'h0F, "w8 div");

        // reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1; sig = FN_MULTU; a = 32'd6; b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst in_ready", 64'(in_ready), 64'd1);
        check("midrst out", 64'(out), 64'd0);
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("midrst no done", 64'(seen), 64'd0);
        m_hi = '0; m_lo = '0;
        op1(FN_MFHI, 0, 0, "midrst hi");
        op1(FN_MFLO, 0, 0, "midrst lo");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
